// File: rtl/multicycle_control.sv
// Multicycle instruction-sequencing FSM driving the ALU, memory, register-file and PC strobes.
// Outputs are registered from the next-state decode, so each output always matches the current state.
module multicycle_control #(
  parameter logic [3:0] ALU_NOP = 4'b1111
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  output logic [3:0] ALU_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       target_write,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RESET      = 4'd0,
    S_FETCH      = 4'd1,
    S_DECODE     = 4'd2,
    S_MEM_ADDR   = 4'd3,
    S_MEM_READ   = 4'd4,
    S_MEM_WB     = 4'd5,
    S_MEM_WRITE  = 4'd6,
    S_EXEC       = 4'd7,
    S_ALU_WB     = 4'd8,
    S_ADDI_EXEC  = 4'd9,
    S_ADDI_WB    = 4'd10,
    S_BRANCH     = 4'd11,
    S_BRANCH_CMP = 4'd12,
    S_JUMP       = 4'd13,
    S_ILLEGAL    = 4'd14,
    S_SPARE      = 4'd15
  } state_t;

  typedef struct packed {
    logic [3:0] alu;
    logic       src_a;
    logic [1:0] src_b;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       target_write;
    logic       illegal_op;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // Returns {legal, alu_op} for an R-type funct field.
  function automatic logic [4:0] funct_decode(input logic [5:0] fn);
    logic [4:0] res;
    case (fn)
      6'b100000: res = {1'b1, ALU_ADD};
      6'b100010: res = {1'b1, ALU_SUB};
      6'b100100: res = {1'b1, ALU_AND};
      6'b100101: res = {1'b1, ALU_OR};
      default:   res = {1'b0, ALU_NOP};
    endcase
    return res;
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  ctrl_t      ctrl_r;
  ctrl_t      ctrl_s;
  logic [4:0] funct_dec_s;
  logic       unused_zero_s;

  // Zero is qualified against pc_write_cond in the datapath, not here.
  assign unused_zero_s = Zero;
  assign funct_dec_s   = funct_decode(funct);

  // Next-state logic, including opcode dispatch from DECODE and MEM_ADDR.
  always_comb begin
    next_state_s = S_RESET;
    case (state_r)
      S_RESET:  next_state_s = S_FETCH;
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct_dec_s[4]) next_state_s = S_EXEC;
            else                next_state_s = S_ILLEGAL;
          end
          OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
          OP_ADDI:      next_state_s = S_ADDI_EXEC;
          OP_BEQ:       next_state_s = S_BRANCH;
          OP_J:         next_state_s = S_JUMP;
          default:      next_state_s = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        case (opcode)
          OP_LW:   next_state_s = S_MEM_READ;
          OP_SW:   next_state_s = S_MEM_WRITE;
          default: next_state_s = S_ILLEGAL;
        endcase
      end
      S_MEM_READ:   next_state_s = S_MEM_WB;
      S_MEM_WB:     next_state_s = S_FETCH;
      S_MEM_WRITE:  next_state_s = S_FETCH;
      S_EXEC:       next_state_s = S_ALU_WB;
      S_ALU_WB:     next_state_s = S_FETCH;
      S_ADDI_EXEC:  next_state_s = S_ADDI_WB;
      S_ADDI_WB:    next_state_s = S_FETCH;
      S_BRANCH:     next_state_s = S_BRANCH_CMP;
      S_BRANCH_CMP: next_state_s = S_FETCH;
      S_JUMP:       next_state_s = S_FETCH;
      S_ILLEGAL:    next_state_s = S_FETCH;
      default:      next_state_s = S_RESET;
    endcase
  end

  // Control decode for the state about to be entered; funct is only consulted while in DECODE.
  always_comb begin
    ctrl_s     = '0;
    ctrl_s.alu = ALU_NOP;
    case (next_state_s)
      S_FETCH: begin
        ctrl_s.mem_read = 1'b1;
        ctrl_s.ir_write = 1'b1;
        ctrl_s.src_b    = 2'b01;
        ctrl_s.alu      = ALU_ADD;
      end
      S_DECODE: begin
        ctrl_s.pc_write = 1'b1;
        ctrl_s.src_b    = 2'b11;
        ctrl_s.alu      = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl_s.src_a = 1'b1;
        ctrl_s.src_b = 2'b10;
        ctrl_s.alu   = ALU_ADD;
      end
      S_MEM_READ: begin
        ctrl_s.mem_read = 1'b1;
        ctrl_s.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_s.mem_write = 1'b1;
        ctrl_s.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_s.src_a = 1'b1;
        ctrl_s.alu   = funct_dec_s[3:0];
      end
      S_ALU_WB: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.reg_dst   = 1'b1;
      end
      S_ADDI_WB:    ctrl_s.reg_write = 1'b1;
      // Target must be latched here, before SUB overwrites ALU_result.
      S_BRANCH: begin
        ctrl_s.target_write = 1'b1;
        ctrl_s.src_a        = 1'b1;
        ctrl_s.alu          = ALU_SUB;
      end
      S_BRANCH_CMP: begin
        ctrl_s.pc_write_cond = 1'b1;
        ctrl_s.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl_s.pc_write  = 1'b1;
        ctrl_s.pc_source = 2'b10;
      end
      S_ILLEGAL: ctrl_s.illegal_op = 1'b1;
      default:   ctrl_s.alu        = ALU_NOP;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= S_RESET;
      ctrl_r     <= '0;
      ctrl_r.alu <= ALU_NOP;
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= ctrl_s;
    end
  end

  assign state         = state_r;
  assign ALU_control   = ctrl_r.alu;
  assign alu_src_a     = ctrl_r.src_a;
  assign alu_src_b     = ctrl_r.src_b;
  assign ir_write      = ctrl_r.ir_write;
  assign mem_read      = ctrl_r.mem_read;
  assign mem_write     = ctrl_r.mem_write;
  assign iord          = ctrl_r.iord;
  assign reg_write     = ctrl_r.reg_write;
  assign reg_dst       = ctrl_r.reg_dst;
  assign mem_to_reg    = ctrl_r.mem_to_reg;
  assign pc_write      = ctrl_r.pc_write;
  assign pc_write_cond = ctrl_r.pc_write_cond;
  assign pc_source     = ctrl_r.pc_source;
  assign target_write  = ctrl_r.target_write;
  assign illegal_op    = ctrl_r.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle expectations, a negedge monitor compares.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Zero;
  logic [3:0] ALU_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ir_write, mem_read, mem_write, iord;
  logic       reg_write, reg_dst, mem_to_reg;
  logic       pc_write, pc_write_cond;
  logic [1:0] pc_source;
  logic       target_write, illegal_op;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .Zero(Zero),
    .ALU_control(ALU_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .target_write(target_write), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [3:0]  alu;
    logic [15:0] sig;
    bit          chk_alu;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [3:0] NOP = 4'b1111;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;

  // Strobe layout: src_a, src_b[2], ir_write, mem_read, mem_write, iord, reg_write,
  // reg_dst, mem_to_reg, pc_write, pc_write_cond, pc_source[2], target_write, illegal_op
  function automatic logic [15:0] strobes(input logic [3:0] st);
    case (st)
      4'd1:    return 16'b0_01_1_1_0_0_0_0_0_0_0_00_0_0;
      4'd2:    return 16'b0_11_0_0_0_0_0_0_0_1_0_00_0_0;
      4'd3:    return 16'b1_10_0_0_0_0_0_0_0_0_0_00_0_0;
      4'd4:    return 16'b0_00_0_1_0_1_0_0_0_0_0_00_0_0;
      4'd5:    return 16'b0_00_0_0_0_0_1_0_1_0_0_00_0_0;
      4'd6:    return 16'b0_00_0_0_1_1_0_0_0_0_0_00_0_0;
      4'd7:    return 16'b1_00_0_0_0_0_0_0_0_0_0_00_0_0;
      4'd8:    return 16'b0_00_0_0_0_0_1_1_0_0_0_00_0_0;
      4'd9:    return 16'b1_10_0_0_0_0_0_0_0_0_0_00_0_0;
      4'd10:   return 16'b0_00_0_0_0_0_1_0_0_0_0_00_0_0;
      4'd11:   return 16'b1_00_0_0_0_0_0_0_0_0_0_00_1_0;
      4'd12:   return 16'b0_00_0_0_0_0_0_0_0_0_1_01_0_0;
      4'd13:   return 16'b0_00_0_0_0_0_0_0_0_1_0_10_0_0;
      4'd14:   return 16'b0_00_0_0_0_0_0_0_0_0_0_00_0_1;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input logic [3:0] alu, input bit chk_alu);
    exp_t e;
    e.st = st; e.alu = alu; e.sig = strobes(st); e.chk_alu = chk_alu;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH: n expected states/ALU codes, packed low nibble first, ending in FETCH.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int n, input logic [23:0] sts, input logic [23:0] alus);
    opcode = op;
    funct  = fn;
    Zero   = z;
    for (int i = 0; i < n; i++) begin
      tick();
      push(sts[4*i +: 4], alus[4*i +: 4], 1'b1);
    end
  endtask

  // Monitor: compares one queued expectation per cycle away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e   = sb.pop_front();
      act = {alu_src_a, alu_src_b, ir_write, mem_read, mem_write, iord, reg_write,
             reg_dst, mem_to_reg, pc_write, pc_write_cond, pc_source, target_write, illegal_op};
      n_cmp++;
      if (state !== e.st) begin
        n_bad++;
        $display("FAIL state @%0t: got %0d expected %0d", $time, state, e.st);
      end
      n_cmp++;
      if (act !== e.sig) begin
        n_bad++;
        $display("FAIL strobes state=%0d @%0t: got %b expected %b", e.st, $time, act, e.sig);
      end
      if (e.chk_alu) begin
        n_cmp++;
        if (ALU_control !== e.alu) begin
          n_bad++;
          $display("FAIL alu_control state=%0d @%0t: got %b expected %b", e.st, $time, ALU_control, e.alu);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    opcode  = 6'b000000;
    funct   = 6'b000000;
    Zero    = 1'b0;
    // Three reset cycles: state 0, all strobes 0
    for (int i = 0; i < 3; i++) begin
      tick();
      push(4'd0, NOP, 1'b0);
    end
    reset_n = 1'b1;
    tick();
    push(4'd1, ADD, 1'b1);

    // R-type add/sub/and/or: 2,7,8,1
    run(6'b000000, 6'b100000, 1'b0, 4, {8'h0, 4'd1, 4'd8, 4'd7, 4'd2}, {8'h0, ADD, NOP, 4'b0010, ADD});
    run(6'b000000, 6'b100010, 1'b0, 4, {8'h0, 4'd1, 4'd8, 4'd7, 4'd2}, {8'h0, ADD, NOP, 4'b0110, ADD});
    run(6'b000000, 6'b100100, 1'b0, 4, {8'h0, 4'd1, 4'd8, 4'd7, 4'd2}, {8'h0, ADD, NOP, 4'b0000, ADD});
    run(6'b000000, 6'b100101, 1'b0, 4, {8'h0, 4'd1, 4'd8, 4'd7, 4'd2}, {8'h0, ADD, NOP, 4'b0001, ADD});
    // lw: 2,3,4,5,1
    run(6'b100011, 6'b000000, 1'b0, 5, {4'h0, 4'd1, 4'd5, 4'd4, 4'd3, 4'd2}, {4'h0, ADD, NOP, NOP, ADD, ADD});
    // sw: 2,3,6,1
    run(6'b101011, 6'b000000, 1'b0, 4, {8'h0, 4'd1, 4'd6, 4'd3, 4'd2}, {8'h0, ADD, NOP, ADD, ADD});
    // addi: 2,9,10,1
    run(6'b001000, 6'b000000, 1'b0, 4, {8'h0, 4'd1, 4'd10, 4'd9, 4'd2}, {8'h0, ADD, NOP, ADD, ADD});
    // beq taken and not taken: identical outputs
    run(6'b000100, 6'b000000, 1'b1, 4, {8'h0, 4'd1, 4'd12, 4'd11, 4'd2}, {8'h0, ADD, NOP, SUB, ADD});
    run(6'b000100, 6'b000000, 1'b0, 4, {8'h0, 4'd1, 4'd12, 4'd11, 4'd2}, {8'h0, ADD, NOP, SUB, ADD});
    // j: 2,13,1
    run(6'b000010, 6'b000000, 1'b0, 3, {12'h0, 4'd1, 4'd13, 4'd2}, {12'h0, ADD, NOP, ADD});
    // Illegal opcode, then R-type with illegal funct: 2,14,1
    run(6'b111111, 6'b000000, 1'b0, 3, {12'h0, 4'd1, 4'd14, 4'd2}, {12'h0, ADD, NOP, ADD});
    run(6'b000000, 6'b101010, 1'b0, 3, {12'h0, 4'd1, 4'd14, 4'd2}, {12'h0, ADD, NOP, ADD});

    // Reset during MEM_WRITE
    opcode = 6'b101011;
    tick(); push(4'd2, ADD, 1'b1);
    tick(); push(4'd3, ADD, 1'b1);
    tick(); push(4'd6, NOP, 1'b1);
    reset_n = 1'b0;
    tick(); push(4'd0, NOP, 1'b0);
    reset_n = 1'b1;
    tick(); push(4'd1, ADD, 1'b1);
    // Execution resumes normally after the mid-op reset
    run(6'b001000, 6'b000000, 1'b0, 4, {8'h0, 4'd1, 4'd10, 4'd9, 4'd2}, {8'h0, ADD, NOP, ADD, ADD});

    @(posedge clk);
    @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle instruction-sequencing FSM that sits directly upstream of the ALU. It decodes the IR opcode/funct fields and drives `ALU_control`, operand-select, memory, register-file and PC-update strobes, one state per cycle. It accounts for the ALU's registered output: a result is valid in the cycle after the operation is presented. It also consumes the ALU's registered `Zero` flag for branch resolution.

## Interface
- `ALU_NOP`, default 4'b1111, meaning: ALU code that matches no ALU operation, so the ALU holds `ALU_result`.
- `clk` in 1 — clock; all state changes on the rising edge.
- `reset_n` in 1 — synchronous, active-low reset.
- `opcode` in 6 — IR[31:26]; valid from DECODE onward.
- `funct` in 6 — IR[5:0].
- `Zero` in 1 — registered zero flag from the ALU.
- `ALU_control` out 4 — ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, else `ALU_NOP`.
- `alu_src_a` out 1 — 0 selects PC, 1 selects reg A.
- `alu_src_b` out 2 — 00 selects reg B, 01 selects constant 4, 10 selects sign-extended imm, 11 selects sign-extended imm<<2.
- `ir_write`, `mem_read`, `mem_write`, `iord` out 1 each — IR load; memory read; memory write; address select (0 selects PC, 1 selects `ALU_result`).
- `reg_write`, `reg_dst`, `mem_to_reg` out 1 each — register-file write enable; destination select (1 selects rd, 0 selects rt); writeback source (1 selects memory data).
- `pc_write`, `pc_write_cond` out 1 each — unconditional PC load; PC load qualified by `Zero`.
- `pc_source` out 2 — 00 selects `ALU_result`, 01 selects branch-target register, 10 selects jump address.
- `target_write` out 1 — datapath latches `ALU_result` into the branch-target register.
- `illegal_op` out 1 — one-cycle pulse on an undecodable instruction.
- `state` out 4 — current state, for debug.

## Operation
- Moore FSM; every output decodes from `state` only. Any signal not listed for a state is 0, and `ALU_control` is `ALU_NOP`.
- States, with encoding, asserted outputs and next state:
  - RESET=0: no outputs asserted → FETCH.
  - FETCH=1: `mem_read`, `ir_write`, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, ADD → DECODE.
  - DECODE=2: `pc_write`, `pc_source`=00 (PC+4 now valid), `alu_src_a`=0, `alu_src_b`=11, ADD → dispatch.
  - MEM_ADDR=3: `alu_src_a`=1, `alu_src_b`=10, ADD → MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ=4: `mem_read`, `iord`=1 → MEM_WB.
  - MEM_WB=5: `reg_write`, `mem_to_reg`=1, `reg_dst`=0 → FETCH.
  - MEM_WRITE=6: `mem_write`, `iord`=1 → FETCH.
  - EXEC=7: `alu_src_a`=1, `alu_src_b`=00, funct-mapped op → ALU_WB.
  - ALU_WB=8: `reg_write`, `reg_dst`=1 → FETCH.
  - ADDI_EXEC=9: `alu_src_a`=1, `alu_src_b`=10, ADD → ADDI_WB.
  - ADDI_WB=10: `reg_write`, `reg_dst`=0 → FETCH.
  - BRANCH=11: `target_write`, `alu_src_a`=1, `alu_src_b`=00, SUB → BRANCH_CMP.
  - BRANCH_CMP=12: `pc_write_cond`, `pc_source`=01 → FETCH.
  - JUMP=13: `pc_write`, `pc_source`=10 → FETCH.
  - ILLEGAL=14: `illegal_op` → FETCH.
  - Encoding 15: no outputs asserted → RESET.
- Dispatch from DECODE:
  - 000000 (R-type) → EXEC, provided funct is legal.
  - 100011 (lw) or 101011 (sw) → MEM_ADDR.
  - 001000 (addi) → ADDI_EXEC.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - Any other opcode → ILLEGAL.
- Funct map: 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001. Any other funct on R-type → ILLEGAL; EXEC is not entered.
- `opcode` and `funct` are sampled only in DECODE and MEM_ADDR. The block has no internal copy.

## Timing
- Reset: while `reset_n`=0 at a rising edge, the next state is RESET and all outputs are 0. This applies from any state, mid-instruction included; no pending strobe survives.
- After release: first cycle is RESET, second cycle is FETCH.
- Latency from FETCH to the next FETCH:
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 4 cycles.
  - j and illegal: 3 cycles.
- ALU result timing: every ALU op presented in state S is read by the datapath in state S+1. States that need a stable `ALU_result` present `ALU_NOP`, so the result holds (for example MEM_READ, MEM_WRITE and BRANCH_CMP).
- Branch: `Zero` is taken in BRANCH_CMP and reflects the SUB from BRANCH. The branch target is computed in DECODE and captured by `target_write` in BRANCH, before SUB overwrites `ALU_result`.
- Exclusivity: `mem_read`, `mem_write` and `reg_write` are never asserted together. `pc_write` and `pc_write_cond` are never asserted together.

## Test plan
- Reset: `reset_n`=0 for 3 cycles → `state`=0, all outputs 0. Release → `state` sequence 0, 1, and `mem_read`=`ir_write`=1 in cycle 2.
- R-type add (opcode 000000, funct 100000) → `state` 1,2,7,8,1. `ALU_control` 0010,0010,0010,1111. `reg_write`=`reg_dst`=1 only in state 8. Repeat for funct 100010, 100100, 100101 → EXEC `ALU_control` 0110, 0000, 0001.
- lw (100011) → `state` 1,2,3,4,5,1, with `iord`=1 in state 4 and `mem_to_reg`=1 in state 5. sw (101011) → 1,2,3,6,1 with a single `mem_write` pulse.
- beq (000100) with `Zero`=1 in state 12 → `target_write`=1 with `ALU_control`=0110 in state 11, then `pc_write_cond`=1 with `pc_source`=01 in state 12. Repeat with `Zero`=0 → identical outputs.
- Illegal cases: opcode 111111, then R-type with funct 101010 → each gives `state` 1,2,14,1 with a one-cycle `illegal_op` and no `reg_write`, `mem_write` or `pc_write` after DECODE.
- Reset mid-operation: `reset_n`=0 while in state 6 (MEM_WRITE) → next cycle `state`=0 and `mem_write`=0. After release, execution restarts at FETCH.
